spi_slave_ctrl: RTL
===================

# spi_slave_ctrl

SPI slave front end for the SPI_SLAVE subsystem. It deserialises 10-bit command/data frames from MOSI and presents each completed frame to the RAM stage as `rx_data` with a one-cycle `rx_valid` strobe. For read-data frames it waits for the RAM's `tx_valid`/`tx_data` response and serialises the 8-bit byte back out on MISO. SPI sampling is done on the system clock: one MOSI bit per `clk` edge while `SS_n` is low.

## Interface
- None: frame width is fixed at 10 bits and read-data width at 8 bits.

- `clk` input 1: system clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `SS_n` input 1: slave select, active-low; high aborts any frame.
- `MOSI` input 1: serial data in, MSB first.
- `tx_data` input 8: read byte from RAM.
- `tx_valid` input 1: `tx_data` valid; may be held high for many cycles.
- `rx_data` output 10: completed frame; bits [9:8] are the command, bits [7:0] the payload.
- `rx_valid` output 1: one-cycle strobe, `rx_data` valid.
- `MISO` output 1: serial data out, MSB first; 0 when not shifting.

## Operation
- **Reset** (`rst_n` = 0 at an edge):
  - state → IDLE; `rx_data` = 0, `rx_valid` = 0, `MISO` = 0.
  - Bit counter = 0, shift registers = 0, `rd_addr_pending` = 0.
- **States**: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- **IDLE**: `SS_n` = 0 → CHK_CMD; otherwise stay.
- **CHK_CMD**: the sampled MOSI is frame bit 9.
  - MOSI = 0 → WRITE.
  - MOSI = 1 and `rd_addr_pending` = 0 → READ_ADD.
  - MOSI = 1 and `rd_addr_pending` = 1 → READ_DATA.
- **WRITE / READ_ADD / READ_DATA receive phase**: shift in frame bits 8..0, one per edge.
  - On the edge capturing bit 0: load `rx_data` with all 10 bits and set `rx_valid` = 1 for exactly that next cycle.
- **`rd_addr_pending` update** (at the `rx_valid` edge, from the completed frame):
  - Set when the frame's [9:8] = 2'b10.
  - Cleared when [9:8] = 2'b11.
  - Unchanged for 2'b00 and 2'b01.
- **After a frame completes**:
  - WRITE and READ_ADD hold until `SS_n` = 1 and ignore further MOSI.
  - READ_DATA enters the wait-for-response phase.
- **READ_DATA transmit**:
  - First edge with `tx_valid` = 1 after the frame: load an 8-bit shift register from `tx_data` and drive `MISO` = `tx_data[7]`.
  - Next 7 edges drive bits 6..0.
  - Following edge drives `MISO` = 0 and marks the phase done.
  - Exactly one byte is sent per READ_DATA frame; `tx_valid` remaining high is ignored after the load.
  - `tx_valid` seen outside the READ_DATA wait phase is ignored.
- **Abort**: `SS_n` = 1 sampled in any non-IDLE state → IDLE next edge.
  - Bit counter cleared; `MISO` = 0.
  - No `rx_valid` for a partial frame.
  - `rd_addr_pending` unchanged.
- **New frame**: only after a return to IDLE (`SS_n` high for ≥ 1 edge).
- **Reset priority**: reset mid-frame or mid-transmit overrides everything and returns to the reset values above.

## Timing
- Edge E0 samples `SS_n` = 0 in IDLE. E1 samples bit 9 (CHK_CMD). E2..E10 sample bits 8..0.
- `rx_valid` is high in the cycle after E10 (latency from `SS_n` fall: 11 edges) and low again after E11.
- `rx_valid` is never high on two consecutive cycles.
- Transmit: if `tx_valid` is first sampled high at edge T, `MISO` carries bit 7 after T, bit 6 after T+1, … bit 0 after T+7, and 0 after T+8.
- With the RAM's 1-cycle response, T = E12 (`MISO` bit 7 valid 12 edges after the `SS_n` sample).
- An abort takes effect one edge after `SS_n` = 1 is sampled.

## Test plan
- **Reset**: hold `rst_n` = 0 for 2 edges with `SS_n` = 0 and MOSI toggling → state IDLE; `rx_valid`, `MISO`, `rx_data` all 0.
- **Write address**: `SS_n` low, shift 10'b00_1010_0101 → one `rx_valid` pulse exactly 11 edges after the `SS_n` sample, `rx_data` = 0x0A5; no MISO activity.
- **Read sequence**:
  - Frame 10'b10_0000_0011 → routed via READ_ADD, `rd_addr_pending` = 1.
  - Next frame 10'b11_0000_0000 → routed via READ_DATA.
  - Model drives `tx_data` = 0xC6 with `tx_valid` one cycle after `rx_valid` → MISO emits 1,1,0,0,0,1,1,0 on consecutive cycles, then 0.
  - `rd_addr_pending` = 0 afterwards.
- **Held `tx_valid`**: keep `tx_valid` high for 20 cycles with `tx_data` = 0xFF during READ_DATA → exactly 8 ones on MISO, then 0.
- **Abort**: raise `SS_n` after 6 bits of a write frame → no `rx_valid`, IDLE next edge. A following full frame 10'b01_1111_0000 gives `rx_data` = 0x1F0.
- **Mid-transmit abort/reset**: raise `SS_n` after bit 4 of a read byte → `MISO` = 0 next edge, IDLE. Repeat with `rst_n` pulsed instead → `rd_addr_pending` also cleared.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front end sampled on the system clock.
// Deserialises 10-bit frames from MOSI (MSB first) into rx_data with a
// one-cycle rx_valid strobe, and for read-data frames serialises the
// 8-bit RAM response back out on MISO (MSB first).
//
// Handshake: rx_valid is a single-cycle strobe qualifying rx_data; there
// is no back-pressure. tx_valid qualifies tx_data and is only honoured
// on the first edge it is seen high while a READ_DATA frame is waiting
// for its response; any other tx_valid activity is ignored.
module spi_slave_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    output logic       MISO,
    output logic [2:0] o_dbg_state,
    output logic       o_dbg_rd_addr_pending
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Transmit sub-phase, only meaningful while in READ_DATA.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_WAIT  = 2'd1,
        TX_SHIFT = 2'd2,
        TX_DONE  = 2'd3
    } tx_phase_t;

    state_t    r_state;
    tx_phase_t r_tx_phase;
    logic [3:0] r_bit_cnt;
    logic [8:0] r_rx_shift;     // frame bits received so far (bit 0 arrives with MOSI)
    logic [9:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_frame_done;
    logic       r_rd_addr_pending;
    logic [7:0] r_tx_shift;
    logic [2:0] r_tx_cnt;
    logic       r_miso;
    logic [9:0] w_frame;

    // Complete frame as it stands on the edge that captures bit 0.
    assign w_frame = {r_rx_shift, MOSI};

    assign rx_data               = r_rx_data;
    assign rx_valid              = r_rx_valid;
    assign MISO                  = r_miso;
    assign o_dbg_state           = r_state;
    assign o_dbg_rd_addr_pending = r_rd_addr_pending;

    // Frame FSM: receive, route, and transmit the read byte; SS_n high aborts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_tx_phase        <= TX_IDLE;
            r_bit_cnt         <= 4'd0;
            r_rx_shift        <= 9'd0;
            r_rx_data         <= 10'd0;
            r_rx_valid        <= 1'b0;
            r_frame_done      <= 1'b0;
            r_rd_addr_pending <= 1'b0;
            r_tx_shift        <= 8'd0;
            r_tx_cnt          <= 3'd0;
            r_miso            <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state != IDLE && SS_n) begin
                // Abort: drop the partial frame; rd_addr_pending survives.
                r_state      <= IDLE;
                r_tx_phase   <= TX_IDLE;
                r_bit_cnt    <= 4'd0;
                r_frame_done <= 1'b0;
                r_miso       <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_bit_cnt    <= 4'd0;
                        r_frame_done <= 1'b0;
                        r_tx_phase   <= TX_IDLE;
                        r_miso       <= 1'b0;
                        if (!SS_n) begin
                            r_state <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        // This edge carries frame bit 9, which picks the route.
                        r_rx_shift <= {8'd0, MOSI};
                        r_bit_cnt  <= 4'd0;
                        if (!MOSI) begin
                            r_state <= WRITE;
                        end else if (r_rd_addr_pending) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!r_frame_done) begin
                            r_rx_shift <= {r_rx_shift[7:0], MOSI};
                            if (r_bit_cnt == 4'd8) begin
                                r_rx_data    <= w_frame;
                                r_rx_valid   <= 1'b1;
                                r_frame_done <= 1'b1;
                                if (w_frame[9:8] == 2'b10) begin
                                    r_rd_addr_pending <= 1'b1;
                                end else if (w_frame[9:8] == 2'b11) begin
                                    r_rd_addr_pending <= 1'b0;
                                end
                                if (r_state == READ_DATA) begin
                                    r_tx_phase <= TX_WAIT;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else if (r_state == READ_DATA) begin
                            case (r_tx_phase)
                                TX_WAIT: begin
                                    if (tx_valid) begin
                                        r_miso     <= tx_data[7];
                                        r_tx_shift <= {tx_data[6:0], 1'b0};
                                        r_tx_cnt   <= 3'd0;
                                        r_tx_phase <= TX_SHIFT;
                                    end
                                end
                                TX_SHIFT: begin
                                    if (r_tx_cnt == 3'd7) begin
                                        r_miso     <= 1'b0;
                                        r_tx_phase <= TX_DONE;
                                    end else begin
                                        r_miso     <= r_tx_shift[7];
                                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                        r_tx_cnt   <= r_tx_cnt + 3'd1;
                                    end
                                end
                                default: begin
                                    r_miso <= 1'b0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
